// File: rtl/alu_seq_unit.sv
// Registered ALU with the 14-op map and an iterative shift-add multiplier that produces the full 2*WIDTH product.
// Latency: 1 cycle for single ops; MUL completes WIDTH cycles after the accepting edge.
// Backpressure: busy is high while a multiply iterates; a start during busy is dropped (no queueing).
module alu_seq_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             cout,
  output logic             zero,
  output logic             neg,
  output logic             err
);

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_NAND = 4'd2;
  localparam logic [3:0] OP_NOR  = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_INC  = 4'd6;
  localparam logic [3:0] OP_DEC  = 4'd7;
  localparam logic [3:0] OP_ADD  = 4'd8;
  localparam logic [3:0] OP_SUB  = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_SHR  = 4'd11;
  localparam logic [3:0] OP_SHL  = 4'd12;
  localparam logic [3:0] OP_ASR  = 4'd13;

  // Index of the final shift-add step; the product is written out on that edge.
  localparam logic [5:0] LAST_STEP = 6'(WIDTH - 1);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t               state;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;
  logic [2*WIDTH-1:0]   acc;
  logic [5:0]           cnt;

  logic [WIDTH-1:0]     op_res;
  logic                 op_c;
  logic                 op_err;
  logic [WIDTH:0]       ext_sum;
  logic [2*WIDTH-1:0]   step_acc;

  // Single-cycle operation result and carry for every opcode except MUL.
  always_comb begin
    op_res  = '0;
    op_c    = 1'b0;
    op_err  = 1'b0;
    ext_sum = '0;
    case (opcode)
      OP_AND:  op_res = in1 & in2;
      OP_OR:   op_res = in1 | in2;
      OP_NAND: op_res = ~(in1 & in2);
      OP_NOR:  op_res = ~(in1 | in2);
      OP_XOR:  op_res = in1 ^ in2;
      OP_NOT:  op_res = ~in1;
      OP_INC: begin
        ext_sum = {1'b0, in1} + {{WIDTH{1'b0}}, 1'b1};
        op_res  = ext_sum[WIDTH-1:0];
        op_c    = ext_sum[WIDTH];
      end
      OP_DEC: begin
        op_res = in1 - {{(WIDTH-1){1'b0}}, 1'b1};
        op_c   = (in1 == '0);
      end
      OP_ADD: begin
        ext_sum = {1'b0, in1} + {1'b0, in2};
        op_res  = ext_sum[WIDTH-1:0];
        op_c    = ext_sum[WIDTH];
      end
      OP_SUB: begin
        // Carry of A + ~B + 1: set means no borrow.
        ext_sum = {1'b0, in1} + {1'b0, ~in2} + {{WIDTH{1'b0}}, 1'b1};
        op_res  = ext_sum[WIDTH-1:0];
        op_c    = ext_sum[WIDTH];
      end
      OP_MUL:  op_res = '0;
      OP_SHR: begin
        op_res = {1'b0, in1[WIDTH-1:1]};
        op_c   = in1[0];
      end
      OP_SHL: begin
        op_res = {in1[WIDTH-2:0], 1'b0};
        op_c   = in1[WIDTH-1];
      end
      OP_ASR: begin
        op_res = {in1[WIDTH-1], in1[WIDTH-1:1]};
        op_c   = in1[0];
      end
      default: op_err = 1'b1;
    endcase
  end

  // One shift-add step: add the shifted multiplicand when the current multiplier LSB is set.
  always_comb begin
    step_acc = mplier[0] ? (acc + mcand) : acc;
  end

  // Control FSM, multiply engine and registered result/flags; done is a one-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      cout      <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (opcode == OP_MUL) begin
              mcand  <= {{WIDTH{1'b0}}, in1};
              mplier <= in2;
              acc    <= '0;
              cnt    <= '0;
              busy   <= 1'b1;
              state  <= S_MUL;
            end else begin
              result    <= op_res;
              result_hi <= '0;
              cout      <= op_c;
              zero      <= (op_res == '0);
              neg       <= op_res[WIDTH-1];
              err       <= op_err;
              done      <= 1'b1;
            end
          end
        end
        S_MUL: begin
          acc    <= step_acc;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 6'd1;
          if (cnt == LAST_STEP) begin
            result    <= step_acc[WIDTH-1:0];
            result_hi <= step_acc[2*WIDTH-1:WIDTH];
            cout      <= 1'b0;
            zero      <= (step_acc == '0);
            neg       <= step_acc[2*WIDTH-1];
            err       <= 1'b0;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_seq_unit.md
Name: alu_seq_unit

Overview:
- Parametrised, registered successor to the team's 8-bit combinational ALU.
- Same 14-operation opcode map, with width generalised to WIDTH bits and results/flags registered.
- Multiply replaced by an iterative shift-add engine that produces the full 2*WIDTH product.
- Sits between the operand registers and accumulator of the DSP datapath; a Start/Busy/Done handshake lets the sequencer stall on multi-cycle ops.

Parameters:
- WIDTH, 8, operand and result width in bits; legal values 4..32.

Ports:
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  asynchronous active-low reset.
- Start  input  1  request; sampled only when Busy=0.
- Opcode  input  4  operation select; sampled with Start.
- In1  input  WIDTH  operand A; sampled with Start.
- In2  input  WIDTH  operand B; sampled with Start.
- Busy  output  1  high while a multiply is iterating.
- Done  output  1  one-cycle pulse when Result and flags are valid.
- Result  output  WIDTH  low word of the result.
- ResultHi  output  WIDTH  high word of the product for MUL; 0 for all other opcodes.
- Cout  output  1  carry/borrow/shifted-out bit.
- Zero  output  1  Result==0; for MUL, {ResultHi,Result}==0.
- Neg  output  1  MSB of Result; for MUL, MSB of ResultHi.
- Err  output  1  illegal opcode (14 or 15).

Behaviour:
- Reset: Rst_n low clears all outputs to 0 and forces state IDLE immediately, independent of Clk, including mid-multiply. Partial products are discarded. First Start is accepted on the first rising edge after Rst_n deasserts.
- States: IDLE, MUL.
- IDLE, Start=1, Opcode!=10:
  - Operation is computed and Result/ResultHi/flags are registered on that edge.
  - Done=1 for the following cycle; state stays IDLE.
  - Single-op latency is 1 cycle; back-to-back Starts yield one result per cycle.
- IDLE, Start=1, Opcode=10:
  - Operands are latched on that edge; product accumulator cleared; counter=0; Busy=1; state goes to MUL.
- MUL: each edge performs one shift-add step on the LSB of the multiplier.
  - On the WIDTH-th step edge: Result/ResultHi get the unsigned product, flags update, Done=1 for one cycle, Busy=0, state goes to IDLE.
  - Done is visible WIDTH cycles after the accepting edge.
- Start while Busy=1 is ignored; no queueing.
- Done, Busy and Start interaction: Done and Busy are never high together. A Start sampled in the cycle Done is high is accepted normally.
- Outputs hold their values until the next accepted operation.
- Opcodes (A=In1, B=In2, all modulo 2^WIDTH unless stated):
  - 0 AND; 1 OR; 2 NAND; 3 NOR; 4 XOR; 5 ~A.
  - 6 A+1; 7 A-1.
  - 8 A+B; 9 A-B (computed as A+~B+1).
  - 10 unsigned A*B.
  - 11 logical A>>1; 12 A<<1; 13 arithmetic A>>>1.
- Cout:
  - ADD and INC: carry out.
  - SUB: carry of A+~B+1, so 1 means no borrow.
  - DEC: 1 when A==0 (wrap).
  - SHR and ASR: A[0]; SHL: A[WIDTH-1].
  - 0 for all other opcodes.
- Err: 1 with Done for opcodes 14/15; Result=ResultHi=0, Zero=1, Cout=0, Neg=0.
- Err is cleared by the next accepted legal op.

Test Plan (WIDTH=8):
- Reset then single ops: ADD 8'hF0+8'h20 -> Done the next cycle, Result=8'h10, Cout=1, Zero=0. SUB 8'h05-8'h05 -> Result=0, Zero=1, Cout=1. DEC 8'h00 -> Result=8'hFF, Cout=1, Neg=1.
- MUL 8'hFF*8'hFF -> Busy high 8 cycles, Done 8 cycles after the accepting edge, ResultHi=8'hFE, Result=8'h01, Neg=1. MUL 0*8'h37 -> Zero=1.
- Start pulsed every cycle during a multiply with an ADD opcode -> ignored. Product unchanged. ADD issued in the Done cycle is accepted, and its result appears the cycle after.
- Rst_n pulsed low mid-multiply (cycle 4) -> all outputs 0 immediately, no Done pulse. A new ADD 1+1 after release gives Result=2.
- Shifts on 8'h81: SHR -> 8'h40, Cout=1. SHL -> 8'h02, Cout=1. ASR -> 8'hC0, Cout=1.
- Opcode 4'hE -> Err=1, Result=0, Zero=1. The following AND 8'hF0&8'h3C gives 8'h30 with Err=0. Repeat the ADD and MUL checks with WIDTH=16: 16'hFFFF*16'h0002 -> ResultHi=16'h0001, Result=16'hFFFE.
